// File: rtl/prog_loader.sv
// Boot-time program loader: parses a LEN / data / CHK byte frame, writes the
// image into instruction memory from address 0 and releases the CPU on a good checksum.
module prog_loader #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [SIZE-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [SIZE-1:0]   mem_wdata,
    output logic              cpu_rstn,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [SIZE-1:0]     sum_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [SIZE-1:0]     mem_wdata_q;
    logic                cpu_rstn_q;
    logic                load_done_q;
    logic                load_err_q;
    logic                accept;
    logic [ADDR_W-1:0]   len_in;

    // Valid/ready: a byte moves on a rising edge where in_valid && in_ready;
    // in_ready depends only on state (and is held low while rstn is asserted).
    assign in_ready = rstn && (state_q != RUN);
    assign accept   = in_valid && in_ready;
    assign len_in   = in_data[ADDR_W-1:0];

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rstn  = cpu_rstn_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rstn_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                // ERR behaves like IDLE: the next accepted byte is a fresh LEN.
                IDLE, ERR: begin
                    if (accept) begin
                        len_q      <= len_in;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        load_err_q <= 1'b0;
                        state_q    <= (len_in == '0) ? CHECK : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q;
                        mem_wdata_q <= in_data;
                        sum_q       <= sum_q + in_data;
                        cnt_q       <= cnt_q + ADDR_W'(1);
                        if (cnt_q == len_q - ADDR_W'(1)) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            state_q     <= RUN;
                            cpu_rstn_q  <= 1'b1;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload) begin
                        state_q     <= IDLE;
                        cpu_rstn_q  <= 1'b0;
                        load_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a frame-level model (byte queue per frame)
// predicts outputs each cycle; a few literal checks pin the model.
module tb_prog_loader;

    logic       clk;
    logic       rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       reload;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rstn;
    logic       load_done;
    logic       load_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  frame_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  tb_mem [256];
    int          writes;
    logic        exp_we, exp_run, exp_err;
    logic [7:0]  exp_addr, exp_wdata;

    prog_loader #(.SIZE(8), .ADDR_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rstn  (cpu_rstn),
        .load_done (load_done),
        .load_err  (load_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // frame-level model: the current frame is simply the list of bytes accepted so far
    task automatic model_accept(input logic [7:0] b);
        int n, len;
        logic [7:0] s;
        if (exp_err) begin
            frame_q.delete();
            exp_err = 1'b0;
        end
        frame_q.push_back(b);
        n   = frame_q.size();
        len = int'(frame_q[0]);
        if (n >= 2 && n <= len + 1) begin
            exp_we    = 1'b1;
            exp_addr  = 8'(n - 2);
            exp_wdata = b;
            exp_q.push_back({8'(n - 2), b});
        end
        if (n == len + 2) begin
            s = 8'h00;
            for (int i = 1; i <= len; i++) s = s + frame_q[i];
            if (b == s) exp_run = 1'b1;
            else        exp_err = 1'b1;
        end
    endtask

    // scoreboard / compare process: checks outputs, then predicts the next edge
    always @(negedge clk) begin
        logic [15:0] w;
        if (!rstn) begin
            frame_q.delete();
            exp_q.delete();
            exp_we  = 1'b0;
            exp_run = 1'b0;
            exp_err = 1'b0;
            chk("rst_outputs", {in_ready, mem_we, mem_addr, mem_wdata, cpu_rstn, load_done, load_err}, '0);
        end else begin
            chk("mem_we", mem_we, exp_we);
            if (exp_we) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (mem_we) begin
                tb_mem[mem_addr] = mem_wdata;
                writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("write_order", {mem_addr, mem_wdata}, w);
                end
            end
            chk("in_ready", in_ready, !exp_run);
            chk("cpu_rstn", cpu_rstn, exp_run);
            chk("load_done", load_done, exp_run);
            chk("load_err", load_err, exp_err);
            exp_we = 1'b0;
            if (exp_run) begin
                if (reload) begin
                    exp_run = 1'b0;
                    frame_q.delete();
                end
            end else if (in_valid) begin
                model_accept(in_data);
            end
        end
    end

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int gap);
        foreach (bytes[i]) send(bytes[i], gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        foreach (tb_mem[i]) tb_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1);

        // basic load
        writes = 0;
        send_frame('{8'h03, 8'h11, 8'h22, 8'h33, 8'h66}, 0);
        chk("basic_done", {cpu_rstn, load_done, load_err, in_ready}, 4'b1100);
        chk("basic_writes", writes, 3);
        chk("basic_mem", {tb_mem[0], tb_mem[1], tb_mem[2]}, 24'h112233);

        // reload, overwrite address 0
        repeat (2) begin @(posedge clk); #1; end
        pulse_reload();
        chk("reload_release", {cpu_rstn, load_done, in_ready}, 3'b001);
        send_frame('{8'h01, 8'hAA, 8'hAA}, 0);
        chk("reload_run", load_done, 1);
        chk("reload_mem", {tb_mem[0], tb_mem[1]}, 16'hAA22);

        // bad checksum, reload ignored in ERR, recovery
        pulse_reload();
        send_frame('{8'h02, 8'h80, 8'h90, 8'h11}, 0);
        chk("bad_err", {load_err, cpu_rstn}, 2'b10);
        pulse_reload();
        chk("err_reload_ignored", {load_err, in_ready}, 2'b11);
        send(8'h01, 0);
        chk("err_cleared", load_err, 0);
        send_frame('{8'h05, 8'h05}, 0);
        chk("recover_run", load_done, 1);

        // wrap with stalls
        pulse_reload();
        writes = 0;
        send_frame('{8'h02, 8'hFF, 8'h02, 8'h01}, 2);
        chk("wrap_run", {cpu_rstn, load_done}, 2'b11);
        chk("wrap_writes", writes, 2);

        // empty images
        pulse_reload();
        writes = 0;
        send_frame('{8'h00, 8'h00}, 0);
        chk("empty_run", load_done, 1);
        chk("empty_writes", writes, 0);
        pulse_reload();
        send_frame('{8'h00, 8'h01}, 0);
        chk("empty_err", load_err, 1);

        // async reset mid-load
        send_frame('{8'h05, 8'h01, 8'h02}, 0);
        chk("mid_we", mem_we, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst", {mem_we, cpu_rstn, load_done, load_err, in_ready}, 5'b0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        send_frame('{8'h01, 8'h07, 8'h07}, 0);
        chk("post_reset_run", load_done, 1);
        chk("post_reset_mem", tb_mem[0], 8'h07);

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
